// File: rtl/block_pixel_streamer.sv
// Output stage of the watermarking datapath: drains MxM result blocks from the
// block buffer, clamps each pixel to 0..255 and streams them one per cycle.
module block_pixel_streamer #(
  parameter int Data_Depth = 8,
  parameter int Acc_Width  = 10,
  parameter int Addr_Width = 12,
  parameter int Size_Width = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [Size_Width-1:0]       N,
  input  logic [6:0]                  M_in,
  input  logic                        blk_ready,
  output logic                        blk_ack,
  output logic                        buf_rd_en,
  output logic [Addr_Width-1:0]       buf_addr,
  input  logic signed [Acc_Width-1:0] buf_rdata,
  output logic [Data_Depth-1:0]       Pixel_Data,
  output logic                        new_pixel,
  output logic [6:0]                  M,
  output logic                        Image_Done,
  output logic                        busy,
  output logic                        cfg_err
);

  // Wide enough for (N/M)^2 with M=1, so the last-block compare never overflows.
  localparam int CntW = 2 * Size_Width;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [6:0]            m_q;
  logic [Addr_Width-1:0] addr_q, last_addr_q;
  logic [CntW-1:0]       blocks_total_q, block_cnt_q;
  logic                  pend_q, rd_vld_q, new_pix_q, done_q, busy_q, cfg_err_q;
  logic [Data_Depth-1:0] pix_q;

  logic [Size_Width-1:0] m_safe, side_blocks;
  logic                  cfg_ok;
  logic [CntW-1:0]       blocks_total_d;
  logic [Addr_Width-1:0] last_addr_d;
  logic                  at_last_addr, at_last_blk;
  logic [Data_Depth-1:0] sat_pix;

  // Divisor forced non-zero so the divider stays defined when M_in is illegal.
  assign m_safe         = (M_in == 7'd0) ? Size_Width'(1) : Size_Width'(M_in);
  assign side_blocks    = N / m_safe;
  assign cfg_ok         = (M_in != 7'd0) && (N != '0) && (M_in <= 7'd64) &&
                          ((N % m_safe) == '0);
  assign blocks_total_d = CntW'(side_blocks) * CntW'(side_blocks);
  assign last_addr_d    = Addr_Width'(M_in) * Addr_Width'(M_in) - Addr_Width'(1);

  assign at_last_addr = (addr_q == last_addr_q);
  assign at_last_blk  = ((block_cnt_q + CntW'(1)) == blocks_total_q);

  always_comb begin
    if (buf_rdata[Acc_Width-1]) begin
      sat_pix = '0;
    end else if (|buf_rdata[Acc_Width-2:Data_Depth]) begin
      sat_pix = '1;
    end else begin
      sat_pix = buf_rdata[Data_Depth-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && cfg_ok) state_d = S_WAIT;
      S_WAIT:  if (blk_ready || pend_q) state_d = S_READ;
      S_READ:  if (at_last_addr) state_d = S_DRAIN;
      S_DRAIN: state_d = at_last_blk ? S_DONE : S_WAIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign buf_rd_en  = (state_q == S_READ);
  assign blk_ack    = (state_q == S_READ) && at_last_addr;
  assign buf_addr   = addr_q;
  assign Pixel_Data = pix_q;
  assign new_pixel  = new_pix_q;
  assign M          = m_q;
  assign Image_Done = done_q;
  assign busy       = busy_q;
  assign cfg_err    = cfg_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      m_q            <= '0;
      addr_q         <= '0;
      last_addr_q    <= '0;
      blocks_total_q <= '0;
      block_cnt_q    <= '0;
      pend_q         <= 1'b0;
      rd_vld_q       <= 1'b0;
      new_pix_q      <= 1'b0;
      pix_q          <= '0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_vld_q  <= buf_rd_en;
      new_pix_q <= rd_vld_q;
      done_q    <= (state_q == S_DONE);
      if (rd_vld_q) pix_q <= sat_pix;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              cfg_err_q      <= 1'b0;
              m_q            <= M_in;
              last_addr_q    <= last_addr_d;
              blocks_total_q <= blocks_total_d;
              block_cnt_q    <= '0;
              busy_q         <= 1'b1;
              pend_q         <= 1'b0;
              addr_q         <= '0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          addr_q <= '0;
          if (blk_ready || pend_q) pend_q <= 1'b0;
        end
        S_READ: begin
          addr_q <= at_last_addr ? '0 : addr_q + Addr_Width'(1);
        end
        S_DRAIN: begin
          block_cnt_q <= block_cnt_q + CntW'(1);
          // A block announced while draining is remembered for the next wait.
          if (blk_ready && !at_last_blk) pend_q <= 1'b1;
        end
        S_DONE: begin
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_pixel_streamer.sv
// Directed bench for block_pixel_streamer: buffer model, stalling producer,
// output monitor, and a linear sequence of checked scenarios.
module tb_block_pixel_streamer;

  logic              clk;
  logic              rst;
  logic              start;
  logic [9:0]        N;
  logic [6:0]        M_in;
  logic              blk_ready;
  logic              blk_ack;
  logic              buf_rd_en;
  logic [11:0]       buf_addr;
  logic signed [9:0] buf_rdata;
  logic [7:0]        Pixel_Data;
  logic              new_pixel;
  logic [6:0]        M;
  logic              Image_Done;
  logic              busy;
  logic              cfg_err;

  block_pixel_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .N          (N),
    .M_in       (M_in),
    .blk_ready  (blk_ready),
    .blk_ack    (blk_ack),
    .buf_rd_en  (buf_rd_en),
    .buf_addr   (buf_addr),
    .buf_rdata  (buf_rdata),
    .Pixel_Data (Pixel_Data),
    .new_pixel  (new_pixel),
    .M          (M),
    .Image_Done (Image_Done),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block buffer with one-cycle registered read.
  logic signed [9:0] mem [0:4095];
  initial buf_rdata = '0;
  always @(posedge clk) if (buf_rd_en) buf_rdata <= mem[buf_addr];

  // Producer: holds ready until ack, then stays low for stall_len cycles.
  logic ready_en;
  int   stall_len;
  int   stall;
  initial stall = 0;
  always @(posedge clk) begin
    if (blk_ack) stall <= stall_len;
    else if (stall != 0) stall <= stall - 1;
  end
  assign blk_ready = ready_en && (stall == 0);

  // Output monitor, sampled on the falling edge.
  logic       mon_clr;
  int         exp_run;
  int         pix_cnt, run, run_err, ack_cnt, done_cnt, done_err, rd_cnt;
  logic       prev_np;
  logic [7:0] cap [0:511];
  always @(negedge clk) begin
    if (mon_clr) begin
      pix_cnt <= 0; run <= 0; run_err <= 0; ack_cnt <= 0;
      done_cnt <= 0; done_err <= 0; rd_cnt <= 0; prev_np <= 1'b0;
    end else begin
      prev_np <= new_pixel;
      if (new_pixel) begin
        if (pix_cnt < 512) cap[pix_cnt[8:0]] <= Pixel_Data;
        pix_cnt <= pix_cnt + 1;
        run     <= run + 1;
      end else if (run != 0) begin
        if (run != exp_run) run_err <= run_err + 1;
        run <= 0;
      end
      if (blk_ack) ack_cnt <= ack_cnt + 1;
      if (buf_rd_en) rd_cnt <= rd_cnt + 1;
      if (Image_Done) begin
        done_cnt <= done_cnt + 1;
        if (!prev_np || new_pixel || busy) done_err <= done_err + 1;
      end
    end
  end

  int total;
  int bad;
  int cyc;
  int guard;
  int se [0:8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [9:0] n, input logic [6:0] m);
    N     = n;
    M_in  = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int c);
    logic seen;
    seen = 1'b0;
    c    = 0;
    while (!seen && c < budget) begin
      step();
      c++;
      if (Image_Done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic check_image(input string tag, input int pixels, input int blocks);
    step();
    chk({tag, "_pix_cnt"}, 32'(pix_cnt), 32'(pixels));
    chk({tag, "_ack_cnt"}, 32'(ack_cnt), 32'(blocks));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_run_err"}, 32'(run_err), 32'd0);
    chk({tag, "_done_err"}, 32'(done_err), 32'd0);
    chk({tag, "_done_pulse"}, 32'(Image_Done), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; start = 1'b0; N = '0; M_in = '0;
    ready_en = 1'b0; stall_len = 0; exp_run = 64; mon_clr = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 10'(i & 255);
    se = '{0, 0, 255, 255, 127, 255, 0, 255, 1};

    // Reset state
    repeat (3) step();
    chk("rst_new_pixel", 32'(new_pixel), 32'd0);
    chk("rst_pixel", 32'(Pixel_Data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_m", 32'(M), 32'd0);
    chk("rst_rd_en", 32'(buf_rd_en), 32'd0);
    chk("rst_ack", 32'(blk_ack), 32'd0);
    chk("rst_done", 32'(Image_Done), 32'd0);
    rst = 1'b1;
    step();
    mon_clr = 1'b0;

    // N=16, M=8, producer always ready: 4 blocks, Image_Done 265 cycles after start
    ready_en = 1'b1;
    exp_run  = 64;
    clear_mon();
    pulse_start(10'd16, 7'd8);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_m", 32'(M), 32'd8);
    wait_done(2000, cyc);
    chk("t1_cycles", 32'(cyc), 32'd265);
    check_image("t1", 256, 4);
    for (int k = 0; k < 256; k++) chk("t1_pixel", 32'(cap[k]), 32'(k % 64));
    chk("t1_hold_pixel", 32'(Pixel_Data), 32'd63);

    // Saturation with a single 3x3 block
    mem[0] = 10'h3FB; mem[1] = 10'd0;   mem[2] = 10'd255;
    mem[3] = 10'd300; mem[4] = 10'd127; mem[5] = 10'd511;
    mem[6] = 10'h200; mem[7] = 10'd256; mem[8] = 10'd1;
    exp_run = 9;
    clear_mon();
    pulse_start(10'd3, 7'd3);
    wait_done(200, cyc);
    chk("t2_cycles", 32'(cyc), 32'd12);
    check_image("t2", 9, 1);
    for (int k = 0; k < 9; k++) chk("t2_sat", 32'(cap[k]), 32'(se[k]));
    for (int i = 0; i < 9; i++) mem[i] = 10'(i);

    // Illegal N=20, M=8, then legal N=16, M=4
    clear_mon();
    pulse_start(10'd20, 7'd8);
    chk("t3_cfg_err", 32'(cfg_err), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    repeat (20) step();
    chk("t3_no_reads", 32'(rd_cnt), 32'd0);
    chk("t3_m_held", 32'(M), 32'd3);
    exp_run = 16;
    clear_mon();
    pulse_start(10'd16, 7'd4);
    chk("t3_cfg_clear", 32'(cfg_err), 32'd0);
    wait_done(2000, cyc);
    chk("t3_cycles", 32'(cyc), 32'd289);
    check_image("t3", 256, 16);
    for (int k = 0; k < 256; k++) chk("t3_pixel", 32'(cap[k]), 32'(k % 16));
    pulse_start(10'd130, 7'd65);
    chk("t3_m65_err", 32'(cfg_err), 32'd1);

    // Largest block M=64 is legal
    exp_run = 4096;
    clear_mon();
    pulse_start(10'd64, 7'd64);
    chk("t3b_cfg_clear", 32'(cfg_err), 32'd0);
    wait_done(5000, cyc);
    chk("t3b_cycles", 32'(cyc), 32'd4099);
    check_image("t3b", 4096, 1);
    pulse_start(10'd16, 7'd0);
    chk("t3b_m0_err", 32'(cfg_err), 32'd1);

    // Producer stalls 10 cycles after each ack
    stall_len = 10;
    exp_run   = 64;
    clear_mon();
    pulse_start(10'd16, 7'd8);
    chk("t4_cfg_clear", 32'(cfg_err), 32'd0);
    wait_done(2000, cyc);
    chk("t4_cycles", 32'(cyc), 32'd292);
    check_image("t4", 256, 4);
    stall_len = 0;
    repeat (12) step();

    // Second start mid-image is ignored
    clear_mon();
    pulse_start(10'd16, 7'd8);
    repeat (99) step();
    pulse_start(10'd8, 7'd4);
    chk("t6_m_kept", 32'(M), 32'd8);
    wait_done(2000, cyc);
    chk("t6_cycles", 32'(cyc), 32'd165);
    check_image("t6", 256, 4);

    // Reset after 100 pixels, then a fresh 8x8 image
    clear_mon();
    pulse_start(10'd16, 7'd8);
    guard = 0;
    while (pix_cnt < 100 && guard < 1000) begin
      step();
      guard++;
    end
    chk("t5_reach_100", 32'(pix_cnt >= 100), 32'd1);
    rst = 1'b0;
    #1;
    chk("t5_async_new_pixel", 32'(new_pixel), 32'd0);
    chk("t5_async_pixel", 32'(Pixel_Data), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_m", 32'(M), 32'd0);
    chk("t5_async_rd_en", 32'(buf_rd_en), 32'd0);
    chk("t5_async_ack", 32'(blk_ack), 32'd0);
    repeat (5) step();
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    rst = 1'b1;
    exp_run = 64;
    clear_mon();
    pulse_start(10'd8, 7'd8);
    wait_done(500, cyc);
    chk("t5_cycles", 32'(cyc), 32'd67);
    check_image("t5", 64, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_pixel_streamer.md
Name: block_pixel_streamer

Overview:
- Output stage of the watermarking datapath, directly upstream of the result checker/output port.
- Drains each processed MxM block from the block result buffer, saturates pixels to 0..255 and emits them one per cycle.
- Pixels are raster order inside a block; blocks go left-to-right along a strip, then strip by strip.
- Drives Pixel_Data, new_pixel, M and Image_Done for an NxN image.

Parameters:
Data_Depth, 8, output pixel width
Acc_Width, 10, signed width of processed pixel read from buffer
Addr_Width, 12, block buffer address width (M max 64)
Size_Width, 10, width of image side N (max 512)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches N, M_in, begins image
N  in  Size_Width  image side length
M_in  in  7  block side length
blk_ready  in  1  processed block fully written to buffer
blk_ack  out  1  one-cycle pulse, buffer may be refilled
buf_rd_en  out  1  buffer read strobe
buf_addr  out  Addr_Width  buffer read address (row*M+col)
buf_rdata  in  Acc_Width  signed pixel, valid cycle after buf_rd_en
Pixel_Data  out  Data_Depth  saturated output pixel
new_pixel  out  1  Pixel_Data valid this cycle
M  out  7  latched block size
Image_Done  out  1  one-cycle pulse after last pixel of image
busy  out  1  image in progress
cfg_err  out  1  sticky; illegal N/M at start

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; all counters 0.
- IDLE:
  - On start, check M_in!=0, N!=0, N%M_in==0 and M_in<=64.
  - If illegal: set cfg_err, stay IDLE. cfg_err clears only on the next legal start.
  - If legal: latch N, M; compute blocks_total=(N/M)^2; clear block_cnt; busy=1; go WAIT_BLK.
- start while busy: ignored.
- WAIT_BLK: wait for blk_ready=1, then go READ with addr=0.
- READ:
  - buf_rd_en=1 every cycle; buf_addr runs 0..M*M-1.
  - On the cycle the last address is issued: blk_ack=1 (single cycle), go DRAIN.
- DRAIN:
  - One cycle; last read data is registered out; block_cnt increments.
  - If block_cnt reaches blocks_total: go DONE. Otherwise go WAIT_BLK.
  - blk_ready sampled in this cycle is not lost: if it is high, WAIT_BLK exits on its first cycle.
- DONE:
  - Image_Done=1 for exactly one cycle, strictly after the final new_pixel (never in the same cycle).
  - busy=0; return to IDLE. M holds its value until the next legal start.
- Latency:
  - buf_rd_en at cycle k → buf_rdata valid k+1 → Pixel_Data/new_pixel registered, visible k+2.
  - Continuous stream within a block: M*M consecutive new_pixel cycles, no gaps.
- Saturation: buf_rdata<0 → 0; buf_rdata>255 → 255; otherwise low Data_Depth bits.
- Pixel_Data holds its last value when new_pixel=0.
- blk_ready while in READ/DRAIN for the current block: treated as level and consumed in the next WAIT_BLK. There is no double-counting because the producer holds blk_ready until it sees blk_ack.
- Counters:
  - buf_addr wraps to 0 at each block start.
  - block_cnt width covers 4096 blocks; N=512, M=8 gives 4096 blocks, so the counter must not overflow before the compare.
- Reset mid-operation: immediate return to IDLE, no Image_Done, outputs zeroed. The next start begins a fresh image.

Test Plan:
- N=16, M=8, buffer preloaded with 0..63, blk_ready held → 4 blocks of 64 consecutive new_pixel; Pixel_Data sequence 0..63 each block; 4 blk_ack pulses; Image_Done one cycle after the 256th pixel.
- Saturation: buf_rdata = -5, 0, 255, 300, 127 → Pixel_Data 0, 0, 255, 255, 127.
- Illegal config: start with N=20, M=8 → cfg_err=1, busy=0, no buf_rd_en. Then start with N=16, M=4 → cfg_err=0 and 16 blocks of 16 pixels.
- Stalled producer: blk_ready low for 10 cycles between blocks → new_pixel gaps only between blocks, never within; total 256 pixels for N=16, M=8.
- Reset asserted after 100 pixels → all outputs 0 asynchronously, no Image_Done. A following start with N=8, M=8 yields 64 pixels and one Image_Done.
- start pulsed again mid-image → ignored; pixel count and Image_Done timing unchanged.
